// File: rtl/tb4004_pkg.sv
// Shared definitions for the 4004-style fetch path: phase encoding,
// two-word opcode values, program counter width and the two-word test.
package tb4004_pkg;

    localparam int PC_W = 12;

    // Instruction-cycle phases, in bus order.
    typedef enum logic [2:0] {
        CYC_A1 = 3'd0,
        CYC_A2 = 3'd1,
        CYC_A3 = 3'd2,
        CYC_M1 = 3'd3,
        CYC_M2 = 3'd4,
        CYC_X1 = 3'd5,
        CYC_X2 = 3'd6,
        CYC_X3 = 3'd7
    } cycle_e;

    // First-word opcodes (OPR) that are followed by a second ROM word.
    localparam logic [3:0] OPR_JCN = 4'd1;
    localparam logic [3:0] OPR_FIM = 4'd2;
    localparam logic [3:0] OPR_JUN = 4'd4;
    localparam logic [3:0] OPR_JMS = 4'd5;
    localparam logic [3:0] OPR_ISZ = 4'd7;

    // FIM shares OPR=2 with SRC; only the even-OPA form carries data.
    function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
        return (opr == OPR_JCN) || (opr == OPR_JUN) || (opr == OPR_JMS) ||
               (opr == OPR_ISZ) || ((opr == OPR_FIM) && !opa[0]);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Multiplexed 4-bit ROM bus between the fetch sequencer (master) and ROM (slave).
// The bus has no handshake: the master owns timing. During A1-A3 the master
// drives an address nibble with dataOe=1; during M1/M2 the slave must present
// the instruction nibble on dataIn before the clock edge that leaves the phase.
interface fetch_sequencer_if;
    logic [3:0] dataIn;
    logic [3:0] dataOut;
    logic       dataOe;
    logic       sync;

    modport master (input dataIn, output dataOut, output dataOe, output sync);
    modport slave  (output dataIn, input dataOut, input dataOe, input sync);
endinterface

// File: rtl/fetch_cycle_counter.sv
// 3-bit instruction-phase counter A1..X3 with hold, plus SYNC decode.
module fetch_cycle_counter
    import tb4004_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   advance_i,
    output cycle_e cycle_o,
    output logic   sync_o
);

    cycle_e cycle_q, cycle_d;

    // Next phase: step forward when allowed, wrapping X3 back to A1.
    always_comb begin
        cycle_d = cycle_q;
        if (advance_i) begin
            if (cycle_q == CYC_X3) begin
                cycle_d = CYC_A1;
            end else begin
                cycle_d = cycle_e'(cycle_q + 3'd1);
            end
        end
    end

    // Phase register; reset aborts any cycle in progress and restarts at A1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= CYC_A1;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_o = cycle_q;
    assign sync_o  = (cycle_q == CYC_X3);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch and bus-timing master for the 4004-style core.
// Drives the PC during A1-A3, captures OPR/OPA (or the second word) during
// M1/M2, increments the PC at M2 and applies jumps / two-word tracking at X3.
// Optional single-step hold: define FETCH_SINGLE_STEP_EN.
module fetch_sequencer
    import tb4004_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET = 12'h000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic            stepReq,
    output logic            halted,
`endif
    fetch_sequencer_if.master bus,
    output logic [2:0]      cycle,
    output logic [3:0]      opr,
    output logic [3:0]      opa,
    output logic [7:0]      operand2,
    output logic            secondWord,
    output logic [PC_W-1:0] pc,
    input  logic            pcLoad,
    input  logic [PC_W-1:0] pcLoadAddr
);

    cycle_e          cycle_w;
    logic            sync_w;
    logic            advance;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      opr_q, opr_d;
    logic [3:0]      opa_q, opa_d;
    logic [7:0]      operand2_q, operand2_d;
    logic            second_word_q, second_word_d;

`ifdef FETCH_SINGLE_STEP_EN
    logic halted_q, halted_d;

    // Single-step hold: release on stepReq while parked, re-park after the
    // X3 edge that finishes an instruction (no second word pending).
    always_comb begin
        halted_d = halted_q;
        if (!stall) begin
            if (halted_q) begin
                if (stepReq) begin
                    halted_d = 1'b0;
                end
            end else if ((cycle_w == CYC_X3) && !second_word_d) begin
                halted_d = 1'b1;
            end
        end
    end

    // Hold flag register; reset parks the sequencer at A1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b1;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign advance = !stall && !halted_q;
    assign halted  = halted_q;
`else
    assign advance = !stall;
`endif

    fetch_cycle_counter u_cycle (
        .clk       (clk),
        .rst       (rst),
        .advance_i (advance),
        .cycle_o   (cycle_w),
        .sync_o    (sync_w)
    );

    // Per-phase updates: capture at M1/M2, PC increment at M2, jump and
    // two-word bookkeeping at X3. A stalled clock changes nothing.
    always_comb begin
        pc_d          = pc_q;
        opr_d         = opr_q;
        opa_d         = opa_q;
        operand2_d    = operand2_q;
        second_word_d = second_word_q;
        if (advance) begin
            unique case (cycle_w)
                CYC_M1: begin
                    if (second_word_q) begin
                        operand2_d[7:4] = bus.dataIn;
                    end else begin
                        opr_d = bus.dataIn;
                    end
                end
                CYC_M2: begin
                    if (second_word_q) begin
                        operand2_d[3:0] = bus.dataIn;
                    end else begin
                        opa_d = bus.dataIn;
                    end
                    pc_d = pc_q + 12'd1;
                end
                CYC_X3: begin
                    if (pcLoad) begin
                        pc_d = pcLoadAddr;
                    end
                    // opr/opa still describe the first word while the second
                    // is in flight, so only test them when no second word is due.
                    second_word_d = second_word_q ? 1'b0 : is_two_word(opr_q, opa_q);
                end
                default: begin
                end
            endcase
        end
    end

    // Fetch-path state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= PC_RESET;
            opr_q         <= 4'd0;
            opa_q         <= 4'd0;
            operand2_q    <= 8'd0;
            second_word_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            opr_q         <= opr_d;
            opa_q         <= opa_d;
            operand2_q    <= operand2_d;
            second_word_q <= second_word_d;
        end
    end

    // Address nibbles on the bus during A1-A3; released otherwise.
    always_comb begin
        bus.dataOut = 4'd0;
        bus.dataOe  = 1'b0;
        unique case (cycle_w)
            CYC_A1: begin
                bus.dataOut = pc_q[3:0];
                bus.dataOe  = 1'b1;
            end
            CYC_A2: begin
                bus.dataOut = pc_q[7:4];
                bus.dataOe  = 1'b1;
            end
            CYC_A3: begin
                bus.dataOut = pc_q[11:8];
                bus.dataOe  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.sync   = sync_w;
    assign cycle      = cycle_w;
    assign opr        = opr_q;
    assign opa        = opa_q;
    assign operand2   = operand2_q;
    assign secondWord = second_word_q;
    assign pc         = pc_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and bus-timing master for the 4004-style core.
- Generates the 8-phase instruction cycle (A1,A2,A3,M1,M2,X1,X2,X3) and the SYNC marker.
- Drives the 12-bit program counter onto the 4-bit multiplexed bus during A1–A3.
- Captures OPR/OPA from the bus during M1/M2 and tracks two-word instructions.
- Its cycle/opr/opa outputs are the inputs consumed by the instruction decoder.

Parameters:
- PC_RESET, 12'h000, program counter value loaded on reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  when high, all state holds for that clock.
- dataIn  in  4  bus nibble from ROM.
- dataOut  out  4  bus nibble driven to ROM (address).
- dataOe  out  1  bus output enable.
- sync  out  1  SYNC marker.
- cycle  out  3  phase: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
- opr  out  4  first-word opcode, upper nibble.
- opa  out  4  first-word operand, lower nibble.
- operand2  out  8  second word of a two-word instruction.
- secondWord  out  1  high while the second word is being fetched.
- pc  out  12  program counter.
- pcLoad  in  1  jump request, sampled only at X3.
- pcLoadAddr  in  12  jump target.

Behaviour:
- Reset (async, rst=1):
  - cycle=0, pc=PC_RESET, opr=0, opa=0, operand2=0, secondWord=0.
  - Bus outputs follow the decode rules below, so dataOe=1 and dataOut=PC_RESET[3:0].
  - Reset mid-instruction aborts the cycle; after release the block starts at A1.
- Cycle counter:
  - Advances by 1 on each clk edge with stall=0; wraps 7→0.
  - stall=1 freezes every register; outputs hold.
- sync = (cycle==7), combinationally decoded from the cycle register. No extra latency.
- Bus drive (combinational from cycle and pc):
  - cycle 0: dataOut=pc[3:0], dataOe=1.
  - cycle 1: dataOut=pc[7:4], dataOe=1.
  - cycle 2: dataOut=pc[11:8], dataOe=1.
  - cycles 3–7: dataOe=0, dataOut=0.
- Capture when secondWord=0:
  - Edge leaving cycle 3: opr<=dataIn.
  - Edge leaving cycle 4: opa<=dataIn.
- Capture when secondWord=1:
  - Edge leaving cycle 3: operand2[7:4]<=dataIn.
  - Edge leaving cycle 4: operand2[3:0]<=dataIn.
  - opr/opa hold the first word.
- PC increment: on the edge leaving cycle 4, pc<=pc+1 mod 4096 (12'hFFF→12'h000).
- Two-word detection, from opr/opa after M2: opr ∈ {1,4,5,7}, or (opr==2 and opa[0]==0).
- secondWord update, on the edge leaving cycle 7:
  - If secondWord=0 and the instruction is two-word: set to 1.
  - If secondWord=1: clear to 0.
- pcLoad:
  - Honoured only on the edge leaving cycle 7; pc<=pcLoadAddr. Ignored in all other cycles.
  - If pcLoad is asserted at X3 of the first word of a two-word instruction, pc loads and the second word is still fetched, from the new pc.
- Simultaneous stall and pcLoad at X3: stall wins; pcLoad is re-evaluated on the next non-stalled X3 edge.

Optional Feature:
- Macro: FETCH_SINGLE_STEP_EN.
- Defined:
  - Adds input stepReq (1 bit) and output halted (1 bit).
  - After an instruction completes (X3 edge with secondWord=0 after the update), the sequencer enters cycle 0 with halted=1 and holds.
  - A stepReq=1 sample releases the hold for exactly one full instruction, including its second word if any.
  - stepReq while running is ignored.
  - Reset leaves the block halted at A1.
- Not defined: free-running; no extra ports.

Decomposition:
- Shared package tb4004_pkg:
  - Cycle phase constants CYC_A1..CYC_X3 (3-bit).
  - Opcode constants for two-word opcodes (OPR_JCN=1, OPR_FIM=2, OPR_JUN=4, OPR_JMS=5, OPR_ISZ=7).
  - PC width constant (12).
- One natural sub-module: fetch_cycle_counter, the 3-bit phase counter with stall hold and the sync decode.
- The pc/capture logic stays in the top module.

Test Plan:
- Reset then run 8 clocks with stall=0 → cycle 0..7 in order; sync only at cycle 7; dataOe=1 only in cycles 0–2; dataOut 0,0,0 with PC_RESET=0.
- Set pc=12'h123 via pcLoad at X3 → next A1/A2/A3 dataOut=3,2,1; after M2 pc=12'h124.
- ROM returns D then 5 (LDM 5) → opr=4'hD from cycle 4 on, opa=4'h5 from cycle 5 on; secondWord stays 0.
- ROM returns 4,2 then 3,4 (JUN) → secondWord=1 for the next instruction cycle; operand2=8'h34; opr/opa stay 4/2; pc advanced by 2.
- Run pc to 12'hFFF → increment at M2 gives 12'h000; stall=1 for 5 clocks mid-M1 → all outputs frozen, resume with no lost phase.
- Assert rst at cycle 5 → immediately cycle=0, pc=PC_RESET, secondWord=0; with FETCH_SINGLE_STEP_EN, halted=1 until a stepReq pulse, then exactly 8 cycles run before halting again.
